// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI slave types, mode decode and synchroniser depth
package spi_slave_pkg;

   localparam int SYNC_DEPTH = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   function automatic logic cpol(input int mode);
      return 1'((mode >> 1) & 1);
   endfunction

   function automatic logic cpha(input int mode);
      return 1'(mode & 1);
   endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - synchronous first-word-fall-through FIFO with registered level
module spi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst,
   input  logic                     i_Push,
   input  logic [WIDTH-1:0]         i_Data,
   input  logic                     i_Pop,
   output logic [WIDTH-1:0]         o_Data,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when the head leaves in the same cycle
   assign do_pop  = i_Pop & ~o_Empty;
   assign do_push = i_Push & (~o_Full | do_pop);

   assign o_Full  = (count == (AW+1)'(DEPTH));
   assign o_Empty = (count == '0);
   assign o_Data  = o_Empty ? '0 : mem[rd_ptr];
   assign o_Level = count;

   // Storage write; contents need no reset because count gates visibility
   always_ff @(posedge i_Clk) begin
      if (do_push) mem[wr_ptr] <= i_Data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - oversampled SPI slave with TX/RX FIFOs; SPI_SLAVE_LEVEL_EN adds level outputs
module spi_slave_fifo
   import spi_slave_pkg::*;
#(
   parameter int                    SPI_MODE      = 0,
   parameter int                    WORD_WIDTH    = 8,
   parameter bit                    MSB_FIRST     = 1'b1,
   parameter int                    TX_DEPTH      = 4,
   parameter int                    RX_DEPTH      = 4,
   parameter logic [WORD_WIDTH-1:0] UNDERRUN_WORD = '0
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst,
   input  logic                       i_TX_Valid,
   output logic                       o_TX_Ready,
   input  logic [WORD_WIDTH-1:0]      i_TX_Word,
   output logic                       o_RX_Valid,
   input  logic                       i_RX_Ready,
   output logic [WORD_WIDTH-1:0]      o_RX_Word,
   input  logic                       i_Clear_Flags,
   output logic                       o_TX_Underrun,
   output logic                       o_RX_Overflow,
   output logic                       o_Frame_Err,
   output logic                       o_Busy,
`ifdef SPI_SLAVE_LEVEL_EN
   output logic [$clog2(TX_DEPTH):0]  o_TX_Level,
   output logic [$clog2(RX_DEPTH):0]  o_RX_Level,
`endif
   input  logic                       i_SPI_Clk,
   input  logic                       i_SPI_MOSI,
   input  logic                       i_SPI_CS_n,
   output logic                       o_SPI_MISO
);
   localparam logic CPOL = cpol(SPI_MODE);
   localparam logic CPHA = cpha(SPI_MODE);
   localparam int   CW   = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

   logic [SYNC_DEPTH:0]   sck_q;
   logic [SYNC_DEPTH:0]   cs_q;
   logic [SYNC_DEPTH-1:0] mosi_q;
   logic sck_s, sck_d, mosi_s, rise, fall, sample_edge, launch_edge, cs_fall, cs_rise;

   state_t state_q, state_d;
   logic   run, entry_load, deassert;

   logic [WORD_WIDTH-1:0] tx_shreg, tx_next, tx_head, rx_shreg, rx_next;
   logic [CW-1:0]         tx_cnt, tx_cnt_next, rx_cnt, rx_cnt_next;
   logic tx_load, tx_shift, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
   logic do_sample, do_launch, miso_q, underrun_set, overflow_set, frame_set;
   logic [$clog2(TX_DEPTH):0] tx_level;
   logic [$clog2(RX_DEPTH):0] rx_level;

   // Pin synchronisers; CS chain resets "asserted" so a reset under a low CS cannot fake a falling edge
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         sck_q  <= {(SYNC_DEPTH+1){CPOL}};
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[SYNC_DEPTH-1:0], i_SPI_Clk};
         cs_q   <= {cs_q[SYNC_DEPTH-1:0], i_SPI_CS_n};
         mosi_q <= {mosi_q[SYNC_DEPTH-2:0], i_SPI_MOSI};
      end
   end

   assign sck_s       = sck_q[SYNC_DEPTH-1];
   assign sck_d       = sck_q[SYNC_DEPTH];
   assign mosi_s      = mosi_q[SYNC_DEPTH-1];
   assign rise        = sck_s & ~sck_d;
   assign fall        = ~sck_s & sck_d;
   assign sample_edge = (CPHA ^ CPOL) ? fall : rise;
   assign launch_edge = (CPHA ^ CPOL) ? rise : fall;
   assign cs_fall     = cs_q[SYNC_DEPTH] & ~cs_q[SYNC_DEPTH-1];
   assign cs_rise     = ~cs_q[SYNC_DEPTH] & cs_q[SYNC_DEPTH-1];

   // Transaction state register
   always_ff @(posedge i_Clk) begin
      if (i_Rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Transaction next state from synchronised CS edges
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Per-state controls; SCK edges only count while selected and not in the release cycle
   always_comb begin
      run        = 1'b0;
      entry_load = 1'b0;
      deassert   = 1'b0;
      case (state_q)
         IDLE:    entry_load = cs_fall & ~CPHA;
         ACTIVE: begin
            deassert = cs_rise;
            run      = ~cs_rise;
         end
         default: ;
      endcase
   end

   assign do_sample    = run & sample_edge;
   assign do_launch    = run & launch_edge;
   assign tx_load      = entry_load | (do_launch & (CPHA ? (tx_cnt == '0) : (tx_cnt == LAST)));
   assign tx_shift     = do_launch & ~tx_load;
   assign rx_push      = do_sample & (rx_cnt == LAST);
   assign rx_pop       = i_RX_Ready & ~rx_empty;
   assign underrun_set = tx_load & tx_empty;
   assign overflow_set = rx_push & rx_full & ~rx_pop;
   assign frame_set    = deassert & (rx_cnt != '0);

   // Shift register and bit counter next values for both directions
   always_comb begin
      tx_next     = tx_shreg;
      tx_cnt_next = tx_cnt;
      rx_next     = rx_shreg;
      rx_cnt_next = rx_cnt;
      if (deassert) begin
         tx_cnt_next = '0;
         rx_cnt_next = '0;
      end else begin
         if (tx_load) begin
            tx_next     = tx_empty ? UNDERRUN_WORD : tx_head;
            tx_cnt_next = CPHA ? CW'(1) : '0;
         end else if (tx_shift) begin
            tx_next     = MSB_FIRST ? (tx_shreg << 1) : (tx_shreg >> 1);
            tx_cnt_next = (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
         end
         if (do_sample) begin
            rx_next     = MSB_FIRST ? {rx_shreg[WORD_WIDTH-2:0], mosi_s}
                                    : {mosi_s, rx_shreg[WORD_WIDTH-1:1]};
            rx_cnt_next = (rx_cnt == LAST) ? '0 : rx_cnt + CW'(1);
         end
      end
   end

   // Datapath registers; MISO register takes the bit of the word being presented
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         tx_shreg <= '0;
         tx_cnt   <= '0;
         rx_shreg <= '0;
         rx_cnt   <= '0;
         miso_q   <= 1'b0;
      end else begin
         tx_shreg <= tx_next;
         tx_cnt   <= tx_cnt_next;
         rx_shreg <= rx_next;
         rx_cnt   <= rx_cnt_next;
         miso_q   <= MSB_FIRST ? tx_next[WORD_WIDTH-1] : tx_next[0];
      end
   end

   // Sticky status flags; a new event beats a simultaneous clear
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_TX_Underrun <= 1'b0;
         o_RX_Overflow <= 1'b0;
         o_Frame_Err   <= 1'b0;
      end else begin
         o_TX_Underrun <= (o_TX_Underrun & ~i_Clear_Flags) | underrun_set;
         o_RX_Overflow <= (o_RX_Overflow & ~i_Clear_Flags) | overflow_set;
         o_Frame_Err   <= (o_Frame_Err & ~i_Clear_Flags) | frame_set;
      end
   end

   spi_sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .i_Clk(i_Clk), .i_Rst(i_Rst),
      .i_Push(i_TX_Valid), .i_Data(i_TX_Word), .i_Pop(tx_load),
      .o_Data(tx_head), .o_Full(tx_full), .o_Empty(tx_empty), .o_Level(tx_level)
   );

   spi_sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .i_Clk(i_Clk), .i_Rst(i_Rst),
      .i_Push(rx_push), .i_Data(rx_next), .i_Pop(rx_pop),
      .o_Data(o_RX_Word), .o_Full(rx_full), .o_Empty(rx_empty), .o_Level(rx_level)
   );

   assign o_TX_Ready = ~tx_full;
   assign o_RX_Valid = ~rx_empty;
   assign o_Busy     = (state_q == ACTIVE);
   assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : miso_q;

`ifdef SPI_SLAVE_LEVEL_EN
   assign o_TX_Level = tx_level;
   assign o_RX_Level = rx_level;
`else
   logic level_unused;
   assign level_unused = ^{tx_level, rx_level};
`endif

endmodule
